alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl_pkg.sv | 45 ++++
 rtl/alu_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl_pkg : ALU opcode map, FSM state encoding and decode helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_seq_ctrl_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_DIV  = 4'b0111;
  localparam logic [3:0] OP_REM  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_ROTL = 4'b1100;
  localparam logic [3:0] OP_ROTR = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC1 = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op == 4'b1110) || (op == 4'b1111);
  endfunction

  function automatic logic op_needs_divisor(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_has_flags(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl : request/response sequencer around an external shared ALU
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_result_hi,
  input  logic        alu_carry,
  input  logic        alu_ovf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_carry,
  output logic        rsp_ovf,
  output logic        rsp_div0,
  output logic        rsp_illegal,
  output logic [15:0] op_count
);

  state_t     r_state;
  logic [3:0] r_op;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= ST_IDLE;
      r_op        <= 4'd0;
      req_ready   <= 1'b1;
      alu_opcode  <= 4'd0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_lo      <= 32'd0;
      rsp_hi      <= 32'd0;
      rsp_carry   <= 1'b0;
      rsp_ovf     <= 1'b0;
      rsp_div0    <= 1'b0;
      rsp_illegal <= 1'b0;
      op_count    <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op      <= req_op;
            req_ready <= 1'b0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
            // Early-out cases leave the ALU inputs untouched so it never sees the op.
            if (op_is_illegal(req_op)) begin
              r_state     <= ST_RESP;
              rsp_valid   <= 1'b1;
              rsp_lo      <= 32'd0;
              rsp_hi      <= 32'd0;
              rsp_div0    <= 1'b0;
              rsp_illegal <= 1'b1;
            end else if (op_needs_divisor(req_op) && (req_b == 32'd0)) begin
              r_state     <= ST_RESP;
              rsp_valid   <= 1'b1;
              rsp_lo      <= 32'd0;
              rsp_hi      <= req_a;
              rsp_div0    <= 1'b1;
              rsp_illegal <= 1'b0;
            end else begin
              r_state    <= ST_EXEC1;
              alu_opcode <= req_op;
              alu_a      <= req_a;
              alu_b      <= req_b;
            end
          end
        end

        ST_EXEC1: begin
          rsp_lo      <= alu_result;
          rsp_hi      <= (r_op == OP_MUL) ? alu_result_hi : 32'd0;
          rsp_carry   <= op_has_flags(r_op) ? alu_carry : 1'b0;
          rsp_ovf     <= op_has_flags(r_op) ? alu_ovf : 1'b0;
          rsp_div0    <= 1'b0;
          rsp_illegal <= 1'b0;
          if (r_op == OP_DIV) begin
            r_state    <= ST_EXEC2;
            alu_opcode <= OP_REM;
          end else begin
            r_state   <= ST_RESP;
            rsp_valid <= 1'b1;
          end
        end

        ST_EXEC2: begin
          rsp_hi    <= alu_result;
          r_state   <= ST_RESP;
          rsp_valid <= 1'b1;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            r_state   <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            op_count  <= op_count + 16'd1;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl : directed vector bench with a behavioural ALU model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [31:0] alu_result_hi;
  logic        alu_carry;
  logic        alu_ovf;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic        rsp_carry;
  logic        rsp_ovf;
  logic        rsp_div0;
  logic        rsp_illegal;
  logic [15:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int g_vec    = -1;
  logic [15:0] exp_count = 16'd0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_result_hi(alu_result_hi),
    .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
    .rsp_div0(rsp_div0), .rsp_illegal(rsp_illegal),
    .op_count(op_count)
  );

  // External ALU model; non-arithmetic ops drive junk flags so masking is visible.
  logic [32:0] sum_w;
  logic [32:0] dif_w;
  logic [63:0] prod_w;
  logic [4:0]  sh_w;
  assign sum_w  = {1'b0, alu_a} + {1'b0, alu_b};
  assign dif_w  = {1'b0, alu_a} - {1'b0, alu_b};
  assign prod_w = {32'd0, alu_a} * {32'd0, alu_b};
  assign sh_w   = alu_b[4:0];

  always_comb begin
    alu_result    = 32'd0;
    alu_result_hi = 32'd0;
    alu_carry     = alu_a[0];
    alu_ovf       = alu_b[0];
    case (alu_opcode)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      OP_ADD: begin
        alu_result = sum_w[31:0];
        alu_carry  = sum_w[32];
        alu_ovf    = (alu_a[31] == alu_b[31]) && (sum_w[31] != alu_a[31]);
      end
      OP_SUB: begin
        alu_result = dif_w[31:0];
        alu_carry  = (alu_a < alu_b);
        alu_ovf    = (alu_a[31] != alu_b[31]) && (dif_w[31] != alu_a[31]);
      end
      OP_MUL: begin
        alu_result    = prod_w[31:0];
        alu_result_hi = prod_w[63:32];
      end
      OP_DIV:  alu_result = (alu_b != 0) ? alu_a / alu_b : 32'hFFFF_FFFF;
      OP_REM:  alu_result = (alu_b != 0) ? alu_a % alu_b : alu_a;
      OP_SLL:  alu_result = alu_a << sh_w;
      OP_SRL:  alu_result = alu_a >> sh_w;
      OP_SRA:  alu_result = $unsigned($signed(alu_a) >>> sh_w);
      OP_ROTL: alu_result = (alu_a << sh_w) | (alu_a >> (6'd32 - {1'b0, sh_w}));
      OP_ROTR: alu_result = (alu_a >> sh_w) | (alu_a << (6'd32 - {1'b0, sh_w}));
      default: alu_result = 32'd0;
    endcase
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        carry;
    logic        ovf;
    logic        div0;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %h, expected %h", name, g_vec, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    int w;
    bit saw_div;
    bit saw_rem;
    saw_div = 1'b0;
    saw_rem = 1'b0;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    saw_div |= (alu_opcode == OP_DIV);
    saw_rem |= (alu_opcode == OP_REM);
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      saw_div |= (alu_opcode == OP_DIV);
      saw_rem |= (alu_opcode == OP_REM);
    end
    check("latency", lat, v.lat);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_lo", rsp_lo, v.lo);
    check("rsp_hi", rsp_hi, v.hi);
    check("rsp_carry", {31'd0, rsp_carry}, {31'd0, v.carry});
    check("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, v.ovf});
    check("rsp_div0", {31'd0, rsp_div0}, {31'd0, v.div0});
    check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, v.ill});
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
    if (v.div0)
      check("alu_saw_div", {31'd0, saw_div}, 32'd0);
    else if (v.op == OP_DIV)
      check("alu_saw_div_rem", {30'd0, saw_div, saw_rem}, 32'd3);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    check("op_count", {16'd0, op_count}, {16'd0, exp_count});
    check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    //          op       a              b              lo             hi            c     o     d0    ill   lat
    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[1]  = '{OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[2]  = '{OP_AND,  32'hF0F0F0F1, 32'h0FF00FF1, 32'h00F000F1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[3]  = '{OP_DIV,  32'd17,       32'd5,        32'd3,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[4]  = '{OP_REM,  32'd17,       32'd5,        32'd2,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[5]  = '{OP_MUL,  32'h12345678, 32'h00000010, 32'h23456780, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[6]  = '{OP_DIV,  32'd9,        32'd0,        32'h0,        32'd9,        1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[7]  = '{OP_REM,  32'h0000DEAD, 32'd0,        32'h0,        32'h0000DEAD, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[8]  = '{4'b1111, 32'd5,        32'd6,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[9]  = '{4'b1110, 32'hFFFFFFFF, 32'd0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{OP_SLL,  32'h00000001, 32'hFFFFFFE4, 32'h00000010, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[11] = '{OP_ROTR, 32'h00000001, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[12] = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 2};

    // Values held while clr is asserted
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    check("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_rsp_lo", rsp_lo, 32'd0);
    check("rst_rsp_hi", rsp_hi, 32'd0);
    clr = 1'b0;

    // Divide abandoned by clr while in EXEC2
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_DIV;
    req_a     = 32'd17;
    req_b     = 32'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("mid_exec1_opcode", {28'd0, alu_opcode}, {28'd0, OP_DIV});
    @(posedge clk);
    #1;
    check("mid_exec2_opcode", {28'd0, alu_opcode}, {28'd0, OP_REM});
    check("mid_exec2_quot", rsp_lo, 32'd3);
    clr = 1'b1;
    #1;
    check("mid_clr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_clr_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_clr_rsp_lo", rsp_lo, 32'd0);
    check("mid_clr_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check("post_clr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_clr_op_count", {16'd0, op_count}, 32'd0);

    // Table of single requests; vector 0 is the add following the abandoned divide
    for (int i = 0; i < 13; i++) begin
      g_vec = i;
      run_op(vecs[i]);
    end
    g_vec = -1;

    // Multiply held under backpressure
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_MUL;
    req_a     = 32'h00010000;
    req_b     = 32'h00010000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_valid_rise", {31'd0, rsp_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_hi", rsp_hi, 32'd1);
      check("bp_rsp_lo", rsp_lo, 32'd0);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    check("bp_op_count", {16'd0, op_count}, {16'd0, exp_count});
    check("bp_req_ready_back", {31'd0, req_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
